alu_op_sequencer: RTL and testbench

- Command-side driver for the 32-bit CLA ALU datapath: accepts an opcode plus two operands on a valid/ready request channel.
- Sequences the ALU control lines (A_invert, B_invert, cin, operation, less) over one or two cycles and returns the registered result and flags on a valid/ready response channel.
- Two-pass SLT/SLTU: pass 1 subtracts and derives `less` from sign/overflow or carry; pass 2 feeds `less` back into bit 0.
- Sits between the issue logic and a combinational alu32 instance.

---
 rtl/alu_op_sequencer_if.sv | 50 +++++
 rtl/alu_op_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bundle of the request, ALU-control and response channels of alu_op_sequencer.
// slave = the sequencer; master = issue logic, ALU and response consumer seen together.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
);
  // Handshake: a beat transfers on a rising edge where valid && ready are both high.
  // The producer holds valid and its payload steady until that edge; ready may depend on state.
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic [WIDTH-1:0] alu_src1;
  logic [WIDTH-1:0] alu_src2;
  logic             alu_a_invert;
  logic             alu_b_invert;
  logic             alu_cin;
  logic [1:0]       alu_operation;
  logic             alu_less;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;
  logic             alu_v;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_v;
  logic             rsp_cout;
  logic             rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready,
    output alu_src1, alu_src2, alu_a_invert, alu_b_invert, alu_cin, alu_operation, alu_less,
    input  alu_result, alu_cout, alu_v,
    output rsp_valid, rsp_result, rsp_zero, rsp_v, rsp_cout, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready,
    input  alu_src1, alu_src2, alu_a_invert, alu_b_invert, alu_cin, alu_operation, alu_less,
    output alu_result, alu_cout, alu_v,
    input  rsp_valid, rsp_result, rsp_zero, rsp_v, rsp_cout, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences ALU control lines for one request; SLT/SLTU take a second pass feeding `less` back.
// Optional macro ALU_OP_SEQUENCER_RSP_FWD_EN: accept the next request while the response is consumed.
module alu_op_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_op_sequencer_if.slave       bus,
  output logic [1:0]              dbg_state_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_CMP2 = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  logic [1:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             less_q, less_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, v_q, v_d, cout_q, cout_d, err_q, err_d;
  logic             req_ready;
  logic             accept;
  logic             op_legal;
  logic             op_cmp;

  always_comb begin
    op_legal = 1'b0;
    case (op_q)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_NOR: op_legal = 1'b1;
      default:                                                 op_legal = 1'b0;
    endcase
  end

  assign op_cmp = (op_q == OP_SLT) || (op_q == OP_SLTU);

`ifdef ALU_OP_SEQUENCER_RSP_FWD_EN
  assign req_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && bus.rsp_ready);
`else
  assign req_ready = (state_q == S_IDLE);
`endif
  assign accept = bus.req_valid && req_ready;

  // ALU control decode: only EXEC and CMP2 drive non-zero controls.
  always_comb begin
    bus.alu_a_invert  = 1'b0;
    bus.alu_b_invert  = 1'b0;
    bus.alu_cin       = 1'b0;
    bus.alu_operation = 2'b00;
    bus.alu_less      = 1'b0;
    if (state_q == S_EXEC) begin
      case (op_q)
        OP_OR:  bus.alu_operation = 2'b01;
        OP_ADD: bus.alu_operation = 2'b10;
        OP_SUB, OP_SLT, OP_SLTU: begin
          bus.alu_operation = 2'b10;
          bus.alu_b_invert  = 1'b1;
          bus.alu_cin       = 1'b1;
        end
        OP_NOR: begin
          bus.alu_a_invert = 1'b1;
          bus.alu_b_invert = 1'b1;
        end
        default: ;
      endcase
    end else if (state_q == S_CMP2) begin
      bus.alu_operation = 2'b11;
      bus.alu_b_invert  = 1'b1;
      bus.alu_cin       = 1'b1;
      bus.alu_less      = less_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    less_d   = less_q;
    result_d = result_q;
    zero_d   = zero_q;
    v_d      = v_q;
    cout_d   = cout_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = bus.req_op;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!op_legal) begin
          result_d = '0;
          zero_d   = 1'b1;
          v_d      = 1'b0;
          cout_d   = 1'b0;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end else if (op_cmp) begin
          // Signed compare corrects the sign bit with overflow; unsigned uses the borrow.
          less_d  = (op_q == OP_SLT) ? (bus.alu_result[WIDTH-1] ^ bus.alu_v) : ~bus.alu_cout;
          v_d     = bus.alu_v;
          cout_d  = bus.alu_cout;
          err_d   = 1'b0;
          state_d = S_CMP2;
        end else begin
          result_d = bus.alu_result;
          zero_d   = (bus.alu_result == '0);
          v_d      = bus.alu_v;
          cout_d   = bus.alu_cout;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end
      end
      S_CMP2: begin
        result_d = bus.alu_result;
        zero_d   = (bus.alu_result == '0);
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          if (accept) begin
            op_d    = bus.req_op;
            a_d     = bus.req_a;
            b_d     = bus.req_b;
            state_d = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      less_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      v_q      <= 1'b0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      less_q   <= less_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      v_q      <= v_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.alu_src1   = a_q;
  assign bus.alu_src2   = b_q;
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_v      = v_q;
  assign bus.rsp_cout   = cout_q;
  assign bus.rsp_err    = err_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 32-bit ALU attached.
module tb_alu_op_sequencer;
  localparam int W = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_CMP2 = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks;
  int         failures;
  logic [W-1:0] exp_q[$];

  alu_op_sequencer_if #(.WIDTH(W)) bus ();

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural ALU: inverters, adder with carry-in, and the bit-0 `less` slice.
  logic [W-1:0] ma, mb;
  logic [W:0]   msum;
  always_comb begin
    ma   = bus.alu_a_invert ? ~bus.alu_src1 : bus.alu_src1;
    mb   = bus.alu_b_invert ? ~bus.alu_src2 : bus.alu_src2;
    msum = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, bus.alu_cin};
    case (bus.alu_operation)
      2'b00:   bus.alu_result = ma & mb;
      2'b01:   bus.alu_result = ma | mb;
      2'b10:   bus.alu_result = msum[W-1:0];
      default: bus.alu_result = {{(W-1){1'b0}}, bus.alu_less};
    endcase
    bus.alu_cout = msum[W];
    bus.alu_v    = (ma[W-1] == mb[W-1]) && (msum[W-1] != ma[W-1]);
  end

  logic [5:0] ctrl;
  assign ctrl = {bus.alu_a_invert, bus.alu_b_invert, bus.alu_cin, bus.alu_operation, bus.alu_less};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic release_rsp();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rel_state", dbg_state, S_IDLE);
    check_eq("rel_req_ready", bus.req_ready, 1);
    check_eq("rel_rsp_valid", bus.rsp_valid, 0);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 16) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq("rsp_valid_seen", bus.rsp_valid, 1);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res, input logic exp_v,
                        input logic exp_cout, input logic exp_err, input logic chk_flags,
                        input logic [5:0] exp_ctrl, input int exp_lat, input logic release_now);
    int lat;
    logic [W-1:0] exp_r;
    @(negedge clk);
    check_eq({name, "_req_ready"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    exp_q.push_back(exp_res);
    @(posedge clk);
    lat = 1;
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq({name, "_exec_ctrl"}, ctrl, exp_ctrl);
    check_eq({name, "_src1"}, bus.alu_src1, a);
    check_eq({name, "_src2"}, bus.alu_src2, b);
    while (!bus.rsp_valid && lat < 16) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (dbg_state == S_CMP2) check_eq({name, "_cmp2_ctrl"}, ctrl, 6'h1E | {5'd0, exp_res[0]});
    end
    check_eq({name, "_rsp_valid"}, bus.rsp_valid, 1);
    check_eq({name, "_latency"}, lat, exp_lat);
    exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check_eq({name, "_result"}, bus.rsp_result, exp_r);
    check_eq({name, "_zero"}, bus.rsp_zero, (exp_r == '0));
    check_eq({name, "_err"}, bus.rsp_err, exp_err);
    if (chk_flags) begin
      check_eq({name, "_v"}, bus.rsp_v, exp_v);
      check_eq({name, "_cout"}, bus.rsp_cout, exp_cout);
    end
    if (release_now) release_rsp();
  endtask

  int lat2;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = 4'd0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", dbg_state, S_IDLE);
    check_eq("rst_req_ready", bus.req_ready, 1);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_ctrl", ctrl, 0);
    check_eq("rst_src1", bus.alu_src1, 0);
    check_eq("rst_rsp_result", bus.rsp_result, 0);
    check_eq("rst_rsp_zero", bus.rsp_zero, 0);
    rst = 1'b0;

    //        name    op       a             b             result        v     cout  err  flags ctrl   lat rel
    run_op("add",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1, 6'h04, 2, 1'b1);
    run_op("sub",  4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 6'h1C, 2, 1'b1);
    run_op("nor",  4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 6'h30, 2, 1'b1);
    run_op("and",  4'b0000, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 2, 1'b1);
    run_op("or",   4'b0001, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 1'b0, 1'b0, 1'b0, 1'b0, 6'h02, 2, 1'b1);
    run_op("slt1", 4'b0111, 32'hFFFFFFFB, 32'h00000003, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b1, 6'h1C, 3, 1'b1);
    run_op("slt2", 4'b0111, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 6'h1C, 3, 1'b1);
    run_op("sltu1",4'b0101, 32'h00000003, 32'hFFFFFFFB, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1, 6'h1C, 3, 1'b1);
    run_op("sltu2",4'b0101, 32'hFFFFFFFB, 32'h00000003, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 6'h1C, 3, 1'b1);
    run_op("ill",  4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 2, 1'b1);

    // Backpressure: the response must hold while rsp_ready stays low.
    run_op("bp",   4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1, 6'h04, 2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_rsp_valid", bus.rsp_valid, 1);
      check_eq("bp_result", bus.rsp_result, 32'h80000000);
      check_eq("bp_v", bus.rsp_v, 1);
      check_eq("bp_req_ready", bus.req_ready, 0);
    end
    release_rsp();

    // Request presented in the cycle the response is consumed.
    run_op("fw0",  4'b0010, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b1, 6'h04, 2, 1'b0);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 4'b0010;
    bus.req_a     = 32'd10;
    bus.req_b     = 32'd20;
`ifdef ALU_OP_SEQUENCER_RSP_FWD_EN
    check_eq("fw_req_ready", bus.req_ready, 1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("fw_state_exec", dbg_state, S_EXEC);
    @(posedge clk);
`else
    check_eq("fw_req_ready", bus.req_ready, 0);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("fw_state_idle", dbg_state, S_IDLE);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
`endif
    wait_rsp(lat2);
    check_eq("fw_result", bus.rsp_result, 32'd30);
    release_rsp();

    // Reset during CMP2 aborts the compare.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 4'b0111;
    bus.req_a     = 32'hFFFFFFFB;
    bus.req_b     = 32'h00000003;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_in_cmp2", dbg_state, S_CMP2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_state", dbg_state, S_IDLE);
    check_eq("abort_rsp_valid", bus.rsp_valid, 0);
    check_eq("abort_req_ready", bus.req_ready, 1);
    check_eq("abort_ctrl", ctrl, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("abort_no_rsp", bus.rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
